// File: rtl/ecliptic_misc_issue.sv
// ecliptic_misc_issue
//
// Issue/sequencing stage for the single-precision "misc" FP operations
// (sign injection, classification and comparison). It accepts one operation
// from upstream, latches the operands and function code, requests the
// matching execution unit, waits for that unit's ack, and holds the result
// until downstream takes it. Only one operation is in flight at a time.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   in_valid / in_ready       upstream handshake (in_ready only in IDLE)
//   in_funct                  000 SGNJ, 001 SGNJN, 010 SGNJX, 011 CLASS,
//                             100 FEQ, 101 FLT, 110 FLE, 111 reserved
//   in_src1, in_src2          operands offered with in_valid
//   src1, src2                latched operands, shared by all units
//   bop_req/op/ack/res        sign-injection unit
//   cls_req/ack/res           classification unit (10-bit class mask)
//   cmp_req/op/ack/res/invalid comparison unit
//   out_valid / out_ready     downstream handshake
//   out_res, out_fflags       result and exception flags (bit4 = NV)
//
// Build option
//   ECLIPTIC_MISC_TIMEOUT_EN  when defined, an 8-bit wait counter abandons a
//                             request after 255 WAIT cycles without an ack
//                             and completes with out_res=0, NV=1. Without
//                             it the stage waits for the ack indefinitely.
module ecliptic_misc_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_funct,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic        bop_req,
  output logic [1:0]  bop_op,
  input  logic        bop_ack,
  input  logic [31:0] bop_res,
  output logic        cls_req,
  input  logic        cls_ack,
  input  logic [9:0]  cls_res,
  output logic        cmp_req,
  output logic [2:0]  cmp_op,
  input  logic        cmp_ack,
  input  logic [31:0] cmp_res,
  input  logic        cmp_invalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [4:0]  out_fflags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F_CLASS = 3'b011;
  localparam logic [2:0] F_FEQ   = 3'b100;
  localparam logic [2:0] F_FLT   = 3'b101;
  localparam logic [2:0] F_FLE   = 3'b110;
  localparam logic [2:0] F_RSVD  = 3'b111;

  state_t      state;
  state_t      state_next;
  logic [2:0]  funct;
  logic        accept;
  logic        is_bop;
  logic        is_cls;
  logic        is_cmp;
  logic        sel_ack;
  logic [31:0] sel_res;
  logic        sel_nv;
  logic [31:0] res_next;
  logic [4:0]  fflags_next;

`ifdef ECLIPTIC_MISC_TIMEOUT_EN
  logic [7:0]  wait_cnt;
  logic        timeout;
`endif

  // Unit selection is decoded from the latched function code so the request
  // and op outputs cannot move while a request is outstanding.
  assign is_bop = (funct[2] == 1'b0) && (funct != F_CLASS);
  assign is_cls = (funct == F_CLASS);
  assign is_cmp = funct[2] && (funct != F_RSVD);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_ready && in_valid;

  assign bop_req = (state == WAIT) && is_bop;
  assign cls_req = (state == WAIT) && is_cls;
  assign cmp_req = (state == WAIT) && is_cmp;

  // SGNJ/SGNJN/SGNJX already encode as 00/01/10 in their low bits.
  assign bop_op = is_bop ? funct[1:0] : 2'b00;

  // The compare unit numbers its ops in the reverse order of the funct code.
  always_comb begin
    cmp_op = 3'b000;
    case (funct)
      F_FLE:   cmp_op = 3'b000;
      F_FLT:   cmp_op = 3'b001;
      F_FEQ:   cmp_op = 3'b010;
      default: cmp_op = 3'b000;
    endcase
  end

  // Only the selected unit's ack and result are looked at; the others are
  // ignored even if they fire.
  always_comb begin
    sel_ack = 1'b0;
    sel_res = 32'd0;
    sel_nv  = 1'b0;
    if (is_bop) begin
      sel_ack = bop_ack;
      sel_res = bop_res;
    end else if (is_cls) begin
      sel_ack = cls_ack;
      sel_res = {22'd0, cls_res};
    end else if (is_cmp) begin
      sel_ack = cmp_ack;
      sel_res = cmp_res;
      sel_nv  = cmp_invalid;
    end
  end

`ifdef ECLIPTIC_MISC_TIMEOUT_EN
  // The counter holds 0 in the first WAIT cycle, so a value of 254 marks the
  // 255th consecutive WAIT cycle without an ack.
  assign timeout = (wait_cnt == 8'd254);
`endif

  always_comb begin
    state_next  = state;
    res_next    = out_res;
    fflags_next = out_fflags;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_funct == F_RSVD) begin
            state_next  = DONE;
            res_next    = 32'd0;
            fflags_next = 5'd0;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (sel_ack) begin
          state_next  = DONE;
          res_next    = sel_res;
          fflags_next = {sel_nv, 4'b0000};
        end
`ifdef ECLIPTIC_MISC_TIMEOUT_EN
        else if (timeout) begin
          state_next  = DONE;
          res_next    = 32'd0;
          fflags_next = 5'b10000;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // out_res/out_fflags only change on completion, so they stay frozen while
  // DONE is back-pressured.
  always_ff @(posedge clk) begin
    if (rst) begin
      funct      <= 3'b000;
      src1       <= 32'd0;
      src2       <= 32'd0;
      out_res    <= 32'd0;
      out_fflags <= 5'd0;
    end else begin
      if (accept) begin
        funct <= in_funct;
        src1  <= in_src1;
        src2  <= in_src2;
      end
      out_res    <= res_next;
      out_fflags <= fflags_next;
    end
  end

`ifdef ECLIPTIC_MISC_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      wait_cnt <= 8'd0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ecliptic_misc_issue.sv
// tb_ecliptic_misc_issue
//
// Drives ecliptic_misc_issue with directed and randomized operations while
// the bench itself plays the three execution units. Expected results come
// from a small table-driven model of the function-code rules.
module tb_ecliptic_misc_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        bop_req;
  logic [1:0]  bop_op;
  logic        bop_ack;
  logic [31:0] bop_res;
  logic        cls_req;
  logic        cls_ack;
  logic [9:0]  cls_res;
  logic        cmp_req;
  logic [2:0]  cmp_op;
  logic        cmp_ack;
  logic [31:0] cmp_res;
  logic        cmp_invalid;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_fflags;

  logic [2:0]  reqs;
  int          checks = 0;
  int          fails  = 0;

  assign reqs = {bop_req, cls_req, cmp_req};

  always #5 clk = ~clk;

  ecliptic_misc_issue dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct    (in_funct),
    .in_src1     (in_src1),
    .in_src2     (in_src2),
    .src1        (src1),
    .src2        (src2),
    .bop_req     (bop_req),
    .bop_op      (bop_op),
    .bop_ack     (bop_ack),
    .bop_res     (bop_res),
    .cls_req     (cls_req),
    .cls_ack     (cls_ack),
    .cls_res     (cls_res),
    .cmp_req     (cmp_req),
    .cmp_op      (cmp_op),
    .cmp_ack     (cmp_ack),
    .cmp_res     (cmp_res),
    .cmp_invalid (cmp_invalid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_res     (out_res),
    .out_fflags  (out_fflags)
  );

  // Which unit a function code talks to, as {bop, cls, cmp}.
  function automatic logic [2:0] exp_reqs(input logic [2:0] f);
    case (f)
      3'd0, 3'd1, 3'd2: return 3'b100;
      3'd3:             return 3'b010;
      3'd4, 3'd5, 3'd6: return 3'b001;
      default:          return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] exp_bop_op(input logic [2:0] f);
    case (f)
      3'd0:    return 2'b00;
      3'd1:    return 2'b01;
      3'd2:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] exp_cmp_op(input logic [2:0] f);
    case (f)
      3'd4:    return 3'b010;
      3'd5:    return 3'b001;
      3'd6:    return 3'b000;
      default: return 3'b000;
    endcase
  endfunction

  // Expected {out_fflags, out_res} given what each unit answers.
  function automatic logic [36:0] model(input logic [2:0] f, input logic [31:0] rb,
                                        input logic [9:0] rc, input logic [31:0] rm,
                                        input logic inv);
    case (exp_reqs(f))
      3'b100:  return {5'd0, rb};
      3'b010:  return {5'd0, 22'd0, rc};
      3'b001:  return {inv, 4'd0, rm};
      default: return 37'd0;
    endcase
  endfunction

  // One complete operation: accept, k WAIT cycles with the ack on cycle k,
  // hold+1 DONE cycles, then release. Non-selected units get random acks.
  task automatic do_op(input string name, input logic [2:0] f,
                       input logic [31:0] s1, input logic [31:0] s2,
                       input int k, input int hold,
                       input logic [31:0] rb, input logic [9:0] rc,
                       input logic [31:0] rm, input logic inv);
    logic [36:0] exp;
    logic [2:0]  er;
    logic [2:0]  garb;
    exp = model(f, rb, rc, rm, inv);
    er  = exp_reqs(f);

    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s accept: in_ready=%b expected 1", name, in_ready);
    end
    in_valid = 1'b1; in_funct = f; in_src1 = s1; in_src2 = s2;
    bop_res = rb; cls_res = rc; cmp_res = rm; cmp_invalid = inv;
    @(negedge clk);
    in_valid = 1'b0; in_funct = 3'($urandom); in_src1 = $urandom; in_src2 = $urandom;

    if (er != 3'b000) begin
      for (int c = 1; c <= k; c++) begin
        checks++;
        if ({out_valid, in_ready, reqs} !== {2'b00, er}) begin
          fails++;
          $display("[TB] FAIL %s wait%0d valid/ready/reqs: got %b expected %b",
                   name, c, {out_valid, in_ready, reqs}, {2'b00, er});
        end
        checks++;
        if ({src1, src2} !== {s1, s2}) begin
          fails++;
          $display("[TB] FAIL %s wait%0d operands: got %h/%h expected %h/%h",
                   name, c, src1, src2, s1, s2);
        end
        if (er != 3'b010) begin
          checks++;
          if ((er[2] && (bop_op !== exp_bop_op(f))) || (er[0] && (cmp_op !== exp_cmp_op(f)))) begin
            fails++;
            $display("[TB] FAIL %s wait%0d op: got bop_op=%b cmp_op=%b expected %b/%b",
                     name, c, bop_op, cmp_op, exp_bop_op(f), exp_cmp_op(f));
          end
        end
        garb = 3'($urandom) & ~er;
        {bop_ack, cls_ack, cmp_ack} = (c == k) ? (garb | er) : garb;
        @(negedge clk);
      end
      {bop_ack, cls_ack, cmp_ack} = 3'b000;
    end

    for (int h = 0; h <= hold; h++) begin
      checks++;
      if ({out_valid, in_ready, reqs} !== 5'b10000) begin
        fails++;
        $display("[TB] FAIL %s done%0d valid/ready/reqs: got %b expected 10000",
                 name, h, {out_valid, in_ready, reqs});
      end
      checks++;
      if ({out_fflags, out_res} !== exp) begin
        fails++;
        $display("[TB] FAIL %s done%0d result: got fflags=%b res=%h expected fflags=%b res=%h",
                 name, h, out_fflags, out_res, exp[36:32], exp[31:0]);
      end
      in_valid = 1'($urandom);
      in_funct = 3'($urandom);
      if (h < hold) begin
        out_ready = 1'b0;
        {bop_ack, cls_ack, cmp_ack} = 3'($urandom);
      end else begin
        out_ready = 1'b1;
        {bop_ack, cls_ack, cmp_ack} = 3'b000;
      end
      @(negedge clk);
    end
    out_ready = 1'b0; in_valid = 1'b0; {bop_ack, cls_ack, cmp_ack} = 3'b000;
    checks++;
    if ({out_valid, in_ready, reqs} !== 5'b01000) begin
      fails++;
      $display("[TB] FAIL %s release valid/ready/reqs: got %b expected 01000",
               name, {out_valid, in_ready, reqs});
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst = 1'b1;
      in_valid = 1'($urandom); in_funct = 3'($urandom);
      in_src1 = $urandom; in_src2 = $urandom;
      {bop_ack, cls_ack, cmp_ack} = 3'($urandom); out_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, reqs} !== 5'b01000) begin
        fails++;
        $display("[TB] FAIL reset%0d valid/ready/reqs: got %b expected 01000",
                 i, {out_valid, in_ready, reqs});
      end
      checks++;
      if ({out_res, out_fflags, src1, src2} !== 101'd0) begin
        fails++;
        $display("[TB] FAIL reset%0d regs: got res=%h ff=%b s1=%h s2=%h expected all 0",
                 i, out_res, out_fflags, src1, src2);
      end
    end
    rst = 1'b0; in_valid = 1'b0; {bop_ack, cls_ack, cmp_ack} = 3'b000; out_ready = 1'b0;
  endtask

  task automatic test_sgnj();
    do_op("sgnj", 3'b000, 32'h3f800000, 32'hcf800000, 2, 0,
          32'hbf800000, 10'($urandom), $urandom, 1'b1);
  endtask

  task automatic test_class();
    do_op("class", 3'b011, 32'h7f800001, $urandom, int'($urandom_range(4, 1)), 1,
          $urandom, 10'h100, $urandom, 1'b1);
  endtask

  task automatic test_flt_invalid();
    do_op("flt_nv", 3'b101, 32'h7f800001, 32'h3f800000, 2, 0,
          $urandom, 10'($urandom), 32'd0, 1'b1);
  endtask

  task automatic test_backpressure();
    do_op("hold", 3'($urandom_range(2, 0)), $urandom, $urandom, 1, 5,
          $urandom, 10'($urandom), $urandom, 1'($urandom));
  endtask

  task automatic test_reserved();
    do_op("rsvd", 3'b111, $urandom, $urandom, 0, 2,
          $urandom, 10'($urandom), $urandom, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      do_op("b2b", 3'($urandom_range(6, 0)), $urandom, $urandom, 1, 0,
            $urandom, 10'($urandom), $urandom, 1'($urandom));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      do_op("rand", 3'($urandom), $urandom, $urandom,
            int'($urandom_range(6, 1)), int'($urandom_range(3, 0)),
            $urandom, 10'($urandom), $urandom, 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_op();
    logic [2:0] f;
    f = 3'($urandom_range(6, 0));
    in_valid = 1'b1; in_funct = f; in_src1 = $urandom; in_src2 = $urandom;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (reqs !== exp_reqs(f)) begin
      fails++;
      $display("[TB] FAIL midrst pre reqs: got %b expected %b", reqs, exp_reqs(f));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, reqs} !== 5'b01000) begin
      fails++;
      $display("[TB] FAIL midrst after valid/ready/reqs: got %b expected 01000",
               {out_valid, in_ready, reqs});
    end
    {bop_ack, cls_ack, cmp_ack} = 3'b111;
    @(negedge clk);
    {bop_ack, cls_ack, cmp_ack} = 3'b000;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({out_valid, in_ready, reqs} !== 5'b01000) begin
        fails++;
        $display("[TB] FAIL midrst late_ack%0d valid/ready/reqs: got %b expected 01000",
                 i, {out_valid, in_ready, reqs});
      end
      @(negedge clk);
    end
  endtask

`ifdef ECLIPTIC_MISC_TIMEOUT_EN
  task automatic test_timeout();
    int high_cycles;
    int n;
    in_valid = 1'b1; in_funct = 3'b100; in_src1 = $urandom; in_src2 = $urandom;
    @(negedge clk);
    in_valid = 1'b0;
    high_cycles = 0;
    n = 0;
    while (!out_valid && n < 400) begin
      if (cmp_req) high_cycles++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (high_cycles !== 255) begin
      fails++;
      $display("[TB] FAIL timeout wait_cycles: got %0d expected 255", high_cycles);
    end
    checks++;
    if ({out_valid, reqs, out_fflags, out_res} !== {1'b1, 3'b000, 5'b10000, 32'd0}) begin
      fails++;
      $display("[TB] FAIL timeout result: got valid=%b reqs=%b ff=%b res=%h expected 1/000/10000/0",
               out_valid, reqs, out_fflags, out_res);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL timeout release: got valid/ready=%b expected 01", {out_valid, in_ready});
    end
  endtask
`else
  task automatic test_timeout();
    do_op("no_timeout", 3'b100, $urandom, $urandom, 300, 0,
          $urandom, 10'($urandom), $urandom, 1'($urandom));
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_funct = 3'd0; in_src1 = 32'd0; in_src2 = 32'd0;
    bop_ack = 1'b0; bop_res = 32'd0; cls_ack = 1'b0; cls_res = 10'd0;
    cmp_ack = 1'b0; cmp_res = 32'd0; cmp_invalid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_sgnj();
    test_class();
    test_flt_invalid();
    test_backpressure();
    test_reserved();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
